// File: rtl/uart_reg_bridge.sv
// UART byte protocol to 32-bit register bus bridge: cmd/addr/[4 data] frames in, one bus access, paced response out.
// reg_req rises the cycle after the last frame byte; each response byte waits for one pacing byte and for tx_busy low.
module uart_reg_bridge #(
  parameter logic [7:0] ACK_BYTE    = 8'hAC,
  parameter logic [7:0] NAK_BYTE    = 8'hEE,
  parameter int         BUS_TIMEOUT = 255,
  parameter int         RX_TIMEOUT  = 500_000
) (
  input  logic        clk,
  input  logic        resetq,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_rd,
  input  logic        tx_busy,
  output logic        tx_wr,
  output logic [7:0]  tx_data,
  output logic        reg_req,
  output logic        reg_we,
  output logic [7:0]  reg_addr,
  output logic [31:0] reg_wdata,
  input  logic [31:0] reg_rdata,
  input  logic        reg_ack
);

  localparam int BW = $clog2(BUS_TIMEOUT + 1);
  localparam int RW = $clog2(RX_TIMEOUT + 1);

  typedef enum logic [2:0] {S_CMD, S_ADDR, S_WDATA, S_BUS, S_PACE, S_SEND} state_t;

  state_t        state_q, state_d;
  logic [7:0]    cmd_q, cmd_d;
  logic [7:0]    addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          to_q, to_d;
  logic [1:0]    idx_q, idx_d;
  logic [2:0]    ridx_q, ridx_d;
  logic [BW-1:0] bus_cnt_q, bus_cnt_d;
  logic [RW-1:0] rx_cnt_q, rx_cnt_d;
  logic          rd_blk_q, tx_grd_q;

  logic       consume_st, timed_st, take, rx_to, last_byte;
  logic [7:0] resp_byte;

  assign consume_st = (state_q == S_CMD) || (state_q == S_ADDR) ||
                      (state_q == S_WDATA) || (state_q == S_PACE);
  assign timed_st   = (state_q == S_ADDR) || (state_q == S_WDATA) || (state_q == S_PACE);
  // rd_blk_q skips the cycle after a read, when buart still shows the old byte as valid.
  assign take       = consume_st && rx_valid && !rd_blk_q;
  assign rx_to      = timed_st && !take && (rx_cnt_q == RW'(RX_TIMEOUT - 1));

  assign rx_rd     = take && resetq;
  assign tx_wr     = (state_q == S_SEND) && !tx_busy && !tx_grd_q;
  assign tx_data   = tx_wr ? resp_byte : 8'h00;
  assign reg_req   = (state_q == S_BUS);
  assign reg_we    = reg_req && !cmd_q[7];
  assign reg_addr  = addr_q;
  assign reg_wdata = wdata_q;

  always_comb begin
    resp_byte = 8'h00;
    last_byte = 1'b1;
    if (!cmd_q[7]) begin
      resp_byte = to_q ? NAK_BYTE : ACK_BYTE;
    end else begin
      last_byte = (ridx_q == 3'd5);
      case (ridx_q)
        3'd0:    resp_byte = cmd_q;
        3'd1:    resp_byte = addr_q;
        3'd2:    resp_byte = rdata_q[7:0];
        3'd3:    resp_byte = rdata_q[15:8];
        3'd4:    resp_byte = rdata_q[23:16];
        3'd5:    resp_byte = rdata_q[31:24];
        default: resp_byte = 8'h00;
      endcase
    end
  end

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    to_d      = to_q;
    idx_d     = idx_q;
    ridx_d    = ridx_q;
    bus_cnt_d = '0;
    if (take || !timed_st)
      rx_cnt_d = '0;
    else
      rx_cnt_d = (rx_cnt_q == RW'(RX_TIMEOUT)) ? rx_cnt_q : rx_cnt_q + 1'b1;

    case (state_q)
      S_CMD: if (take) begin
        cmd_d   = rx_data;
        state_d = S_ADDR;
      end
      S_ADDR: if (take) begin
        addr_d  = rx_data;
        idx_d   = 2'd0;
        state_d = cmd_q[7] ? S_BUS : S_WDATA;
      end else if (rx_to) begin
        state_d = S_CMD;
      end
      S_WDATA: if (take) begin
        wdata_d[{idx_q, 3'b000} +: 8] = rx_data;
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd3) state_d = S_BUS;
      end else if (rx_to) begin
        state_d = S_CMD;
      end
      S_BUS: begin
        bus_cnt_d = (bus_cnt_q == '1) ? bus_cnt_q : bus_cnt_q + 1'b1;
        // An ack in the final allowed cycle still wins over the timeout.
        if (reg_ack) begin
          rdata_d = reg_rdata;
          to_d    = 1'b0;
          ridx_d  = 3'd0;
          state_d = S_PACE;
        end else if (bus_cnt_q == BW'(BUS_TIMEOUT - 1)) begin
          rdata_d = 32'hFFFF_FFFF;
          to_d    = 1'b1;
          ridx_d  = 3'd0;
          state_d = S_PACE;
        end
      end
      S_PACE: if (take) begin
        state_d = S_SEND;
      end else if (rx_to) begin
        state_d = S_CMD;
      end
      S_SEND: if (tx_wr) begin
        ridx_d  = ridx_q + 3'd1;
        state_d = last_byte ? S_CMD : S_PACE;
      end
      default: state_d = S_CMD;
    endcase
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      state_q   <= S_CMD;
      cmd_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      to_q      <= 1'b0;
      idx_q     <= '0;
      ridx_q    <= '0;
      bus_cnt_q <= '0;
      rx_cnt_q  <= '0;
      rd_blk_q  <= 1'b0;
      tx_grd_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      to_q      <= to_d;
      idx_q     <= idx_d;
      ridx_q    <= ridx_d;
      bus_cnt_q <= bus_cnt_d;
      rx_cnt_q  <= rx_cnt_d;
      rd_blk_q  <= take;
      tx_grd_q  <= tx_wr;
    end
  end

endmodule

// File: tb/tb_uart_reg_bridge.sv
// Bench for uart_reg_bridge: vector table of frames plus abort/reset sequences, tx and bus scoreboards.
module tb_uart_reg_bridge;
  localparam int RXTO = 64;

  logic        clk = 1'b0;
  logic        resetq, rx_valid, rx_rd, tx_busy, tx_wr, reg_req, reg_we, reg_ack;
  logic [7:0]  rx_data, tx_data, reg_addr;
  logic [31:0] reg_wdata, reg_rdata;

  always #5 clk = ~clk;

  uart_reg_bridge #(.RX_TIMEOUT(RXTO)) dut (
    .clk(clk), .resetq(resetq), .rx_valid(rx_valid), .rx_data(rx_data), .rx_rd(rx_rd),
    .tx_busy(tx_busy), .tx_wr(tx_wr), .tx_data(tx_data), .reg_req(reg_req), .reg_we(reg_we),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_rdata(reg_rdata), .reg_ack(reg_ack)
  );

  typedef struct {
    logic [7:0]  cmd;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          ack_dly;
    int          busy_len;
    logic [7:0]  exp_wresp;
    logic [31:0] exp_rdata;
    int          exp_dur;
  } vec_t;

  typedef struct packed {
    logic        we;
    logic [7:0]  addr;
    logic [31:0] wdata;
  } bus_t;

  int          total = 0, bad = 0;
  logic [7:0]  exp_tx[$];
  bus_t        exp_bus[$];
  int          ack_dly = -1, busy_len = 0, busy_left = 0, req_cycles = 0, last_dur = 0;
  int          since_tx = 100, rxrd_cnt = 0, bus_seen = 0;
  logic [31:0] rdata_val = 32'h0;
  vec_t        tbl[7];

  // Buart tx side, bus responder and output scoreboards.
  initial begin
    logic [7:0] e;
    bus_t       b;
    tx_busy = 1'b0; reg_ack = 1'b0; reg_rdata = 32'h0;
    forever begin
      @(negedge clk);
      tx_busy = (busy_left != 0);
      if (busy_left != 0) busy_left--;
      reg_ack = 1'b0;
      #1;
      since_tx++;
      if (rx_rd) rxrd_cnt++;
      if (tx_wr) begin
        total++;
        if (exp_tx.size() == 0) begin
          bad++; $display("FAIL tx_unexpected got=%02h want=none", tx_data);
        end else begin
          e = exp_tx.pop_front();
          if (tx_data !== e) begin bad++; $display("FAIL tx_byte got=%02h want=%02h", tx_data, e); end
        end
        total++;
        if (since_tx < 2) begin bad++; $display("FAIL tx_spacing got=%0d want>=2", since_tx); end
        since_tx  = 0;
        busy_left = busy_len;
      end
      if (reg_req) begin
        if (req_cycles == 0) begin
          bus_seen++; total++;
          if (exp_bus.size() == 0) begin
            bad++; $display("FAIL bus_unexpected we=%0b addr=%02h", reg_we, reg_addr);
          end else begin
            b = exp_bus.pop_front();
            if (reg_we !== b.we || reg_addr !== b.addr || (b.we && reg_wdata !== b.wdata)) begin
              bad++;
              $display("FAIL bus_txn got=%0b/%02h/%08h want=%0b/%02h/%08h",
                       reg_we, reg_addr, reg_wdata, b.we, b.addr, b.wdata);
            end
          end
        end
        req_cycles++;
        if (ack_dly >= 0 && req_cycles == ack_dly + 1) begin
          reg_ack = 1'b1; reg_rdata = rdata_val;
        end
      end else if (req_cycles != 0) begin
        last_dur = req_cycles; req_cycles = 0;
      end
    end
  end

  task automatic check(input string name, input int got, input int want);
    total++;
    if (got != want) begin bad++; $display("FAIL %s got=%0d want=%0d", name, got, want); end
  endtask

  // Presents one byte, waits for the read strobe, keeps valid one extra cycle like buart does.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    rx_data = b; rx_valid = 1'b1;
    #1;
    while (!rx_rd && n < 1000) begin @(negedge clk); #1; n++; end
    if (!rx_rd) begin
      total++; bad++; $display("FAIL rx_rd_timeout byte=%02h waited=%0d", b, n);
      @(negedge clk); rx_valid = 1'b0;
      return;
    end
    @(negedge clk);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    bus_t b;
    int   nresp, r0, n;
    ack_dly = v.ack_dly; busy_len = v.busy_len; rdata_val = v.rdata;
    b.we = !v.cmd[7]; b.addr = v.addr; b.wdata = v.wdata;
    exp_bus.push_back(b);
    if (v.cmd[7]) begin
      nresp = 6;
      exp_tx.push_back(v.cmd); exp_tx.push_back(v.addr);
      for (int i = 0; i < 4; i++) exp_tx.push_back(v.exp_rdata[8*i +: 8]);
    end else begin
      nresp = 1;
      exp_tx.push_back(v.exp_wresp);
    end
    r0 = rxrd_cnt;
    send_byte(v.cmd);
    send_byte(v.addr);
    if (!v.cmd[7]) for (int i = 0; i < 4; i++) send_byte(v.wdata[8*i +: 8]);
    for (int i = 0; i < nresp; i++) send_byte(8'h5A + 8'(i));
    n = 0;
    while (exp_tx.size() != 0 && n < 2000) begin @(negedge clk); n++; end
    check("tx_drain_left", exp_tx.size(), 0);
    exp_tx.delete();
    repeat (3) @(negedge clk);
    check("req_duration", last_dur, v.exp_dur);
    check("rx_rd_count", rxrd_cnt - r0, 2 + (v.cmd[7] ? 0 : 4) + nresp);
  endtask

  initial begin
    vec_t abort_follow;
    bus_t b;
    int   seen0;
    tbl[0] = '{8'h00, 8'h10, 32'h12345678, 32'h0,        2,   0, 8'hAC, 32'h0,        3};
    tbl[1] = '{8'h80, 8'h10, 32'h0,        32'hDEADBEEF, 1,   0, 8'h00, 32'hDEADBEEF, 2};
    tbl[2] = '{8'h00, 8'h33, 32'hCAFE0001, 32'h0,        -1,  0, 8'hEE, 32'h0,        255};
    tbl[3] = '{8'h80, 8'h44, 32'h0,        32'h11111111, -1,  0, 8'h00, 32'hFFFFFFFF, 255};
    tbl[4] = '{8'h85, 8'h55, 32'h0,        32'h0BADF00D, 254, 0, 8'h00, 32'h0BADF00D, 255};
    tbl[5] = '{8'h00, 8'hFF, 32'hA5A50F0F, 32'h0,        0,  20, 8'hAC, 32'h0,        1};
    tbl[6] = '{8'hC3, 8'h7E, 32'h0,        32'h01020304, 5,  15, 8'h00, 32'h01020304, 6};
    abort_follow = '{8'h80, 8'h20, 32'h0, 32'h55AA33CC, 3, 0, 8'h00, 32'h55AA33CC, 4};

    resetq = 1'b0; rx_valid = 1'b1; rx_data = 8'h00;
    repeat (2) @(negedge clk);
    #1;
    check("reset_outputs", {rx_rd, tx_wr, reg_req, reg_we, tx_data, reg_addr, reg_wdata}, 0);
    @(negedge clk);
    rx_valid = 1'b0; resetq = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) run_vec(tbl[i]);

    // Frame stalls in WDATA past the idle limit: no bus access, next frame is clean.
    seen0 = bus_seen;
    send_byte(8'h00); send_byte(8'h10); send_byte(8'h78);
    repeat (RXTO + 20) @(negedge clk);
    check("abort_no_bus", bus_seen - seen0, 0);
    run_vec(abort_follow);

    // Reset while a read waits in BUS.
    ack_dly = -1;
    b.we = 1'b0; b.addr = 8'h10; b.wdata = 32'h0;
    exp_bus.push_back(b);
    send_byte(8'h80); send_byte(8'h10);
    repeat (10) @(negedge clk);
    check("bus_req_before_reset", reg_req, 1);
    resetq = 1'b0; rx_valid = 1'b1; rx_data = 8'h99;
    #1;
    check("reset_mid_bus_outputs", {reg_req, tx_wr, rx_rd, reg_we}, 0);
    repeat (2) @(negedge clk);
    resetq = 1'b1; rx_valid = 1'b0;
    @(negedge clk);
    run_vec(tbl[0]);

    check("bus_queue_left", exp_bus.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
